// File: rtl/bp_btb_2bc.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module bp_btb_2bc #(
    parameter int PC_WIDTH = 16,
    parameter int ENTRIES  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                upd_pred_taken,
    input  logic [PC_WIDTH-1:0] upd_pred_target,
    output logic                mispredict,
    output logic [PC_WIDTH-1:0] redirect_pc
`ifdef BTB_STATS_EN
    ,
    output logic [15:0]         stat_lookups,
    output logic [15:0]         stat_hits,
    output logic [15:0]         stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W;

    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic                r_mispredict;
    logic [PC_WIDTH-1:0] r_redirect_pc;

    logic [IDX_W-1:0]    w_f_idx;
    logic [TAG_W-1:0]    w_f_tag;
    logic                w_f_hit;
    logic [IDX_W-1:0]    w_u_idx;
    logic [TAG_W-1:0]    w_u_tag;
    logic                w_u_hit;
    logic                w_mispredict;

    assign w_f_idx = fetch_pc[IDX_W-1:0];
    assign w_f_tag = fetch_pc[PC_WIDTH-1:IDX_W];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    // Lookup sees array contents before any same-cycle update; no bypass.
    assign pred_taken  = w_f_hit & r_ctr[w_f_idx][1];
    assign pred_target = pred_taken ? r_target[w_f_idx] : fetch_pc + PC_WIDTH'(1);

    assign w_u_idx = upd_pc[IDX_W-1:0];
    assign w_u_tag = upd_pc[PC_WIDTH-1:IDX_W];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    assign w_mispredict = upd_valid &
                          ((upd_pred_taken != upd_taken) |
                           (upd_taken & (upd_pred_target != upd_target)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_u_hit) begin
                if (upd_taken) begin
                    r_target[w_u_idx] <= upd_target;
                    if (r_ctr[w_u_idx] != 2'b11) begin
                        r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
                    end
                end else if (r_ctr[w_u_idx] != 2'b00) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Direct-mapped: a taken miss always evicts whatever sits at the index.
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= upd_target;
                r_ctr[w_u_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_mispredict <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= upd_taken ? upd_target : upd_pc + PC_WIDTH'(1);
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;

`ifdef BTB_STATS_EN
    logic [15:0] r_stat_lookups;
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_lookups     <= '0;
            r_stat_hits        <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (r_stat_lookups != 16'hFFFF) begin
                r_stat_lookups <= r_stat_lookups + 16'd1;
            end
            if (w_f_hit && (r_stat_hits != 16'hFFFF)) begin
                r_stat_hits <= r_stat_hits + 16'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != 16'hFFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_hits        = r_stat_hits;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
